// File: rtl/codi_pkg.sv
// Shared types and constants for the CODI arbiter slice.
package codi_pkg;

  localparam int DATA_W = 4;
  localparam int CODE_W = 8;

  // Output stage occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } codi_state_t;

  // Requester index (two requesters).
  typedef logic req_idx_t;

  localparam req_idx_t REQ0 = 1'b0;
  localparam req_idx_t REQ1 = 1'b1;

  // Even parity over three bits; used for the Hamming check bits.
  function automatic logic parity3(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

endpackage

// File: rtl/codi_rr_grant.sv
// Two-way round-robin grant; remembers the last accepted requester.
module codi_rr_grant
  import codi_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_accept,
  output logic o_gnt,
  output logic o_any
);

  req_idx_t r_last;

  // Pick the only valid requester, or the one not served last on a tie.
  always_comb begin
    o_gnt = REQ0;
    if (i_valid0 && i_valid1) o_gnt = ~r_last;
    else if (i_valid1)        o_gnt = REQ1;
  end

  assign o_any = i_valid0 | i_valid1;

  // Last-grant moves only when a word is actually taken; reset favours req0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_last <= REQ1;
    else if (i_accept) r_last <= o_gnt;
  end

endmodule

// File: rtl/module_codi.sv
// Combinational extended Hamming (8,4) SECDED encoder.
// Bit i of the code is Hamming position i: 1,2,4 are check bits,
// 3,5,6,7 carry data bits 0..3, bit 0 is overall parity.
module module_codi
  import codi_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  output logic [CODE_W-1:0] o_code
);

  logic w_p1, w_p2, w_p4, w_p0;

  assign w_p1 = parity3(i_data[0], i_data[1], i_data[3]);
  assign w_p2 = parity3(i_data[0], i_data[2], i_data[3]);
  assign w_p4 = parity3(i_data[1], i_data[2], i_data[3]);
  // Overall parity makes the full 8-bit word even, enabling double-error detect.
  assign w_p0 = ^{i_data, w_p1, w_p2, w_p4};

  assign o_code = {i_data[3], i_data[2], i_data[1], w_p4,
                   i_data[0], w_p2, w_p1, w_p0};

endmodule

// File: rtl/codi_arbiter.sv
// Two requesters share one Hamming encoder feeding a one-entry output stage.
module codi_arbiter
  import codi_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [3:0]        req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [3:0]        req1_data,
  output logic              req1_ready,
  output logic              out_valid,
  output logic [7:0]        out_data,
  output logic              out_src,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  codi_state_t             r_state, w_state_nxt;
  logic [CODE_W-1:0]       r_data;
  req_idx_t                r_src;
  logic [1:0][CNT_W-1:0]   r_cnt;

  logic                    w_free, w_accept, w_any;
  req_idx_t                w_gnt;
  logic [DATA_W-1:0]       w_mux_data;
  logic [CODE_W-1:0]       w_code;
  logic [1:0]              w_acc_n;

  // Stage can take a word if empty or its word leaves this cycle.
  assign w_free   = (r_state == EMPTY) || out_ready;
  assign w_accept = !rst && w_free && w_any;

  codi_rr_grant u_grant (
    .clk      (clk),
    .rst      (rst),
    .i_valid0 (req0_valid),
    .i_valid1 (req1_valid),
    .i_accept (w_accept),
    .o_gnt    (w_gnt),
    .o_any    (w_any)
  );

  assign w_acc_n[0] = w_accept && (w_gnt == REQ0);
  assign w_acc_n[1] = w_accept && (w_gnt == REQ1);

  assign req0_ready = w_acc_n[0];
  assign req1_ready = w_acc_n[1];

  assign w_mux_data = (w_gnt == REQ1) ? req1_data : req0_data;

  module_codi u_enc (
    .i_data (w_mux_data),
    .o_code (w_code)
  );

  // Stage occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Fill on accept; drain only when consumed with nothing replacing it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_accept) w_state_nxt = FULL;
      FULL:    if (out_ready && !w_accept) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Payload register; holds during stall, overwritten on every accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_src  <= REQ0;
    end else if (w_accept) begin
      r_data <= w_code;
      r_src  <= w_gnt;
    end
  end

  // Per-requester saturating accept counters.
  for (genvar n = 0; n < 2; n++) begin : g_cnt
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                r_cnt[n] <= '0;
      else if (w_acc_n[n] && (r_cnt[n] != '1)) r_cnt[n] <= r_cnt[n] + 1'b1;
    end
  end

  assign out_valid = (r_state == FULL);
  assign out_data  = r_data;
  assign out_src   = r_src;
  assign cnt0      = r_cnt[0];
  assign cnt1      = r_cnt[1];

endmodule

// File: tb/tb_codi_arbiter.sv
// Self-checking bench for codi_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_codi_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req1_valid, out_ready;
  logic [3:0] req0_data, req1_data;
  logic req0_ready, req1_ready, out_valid, out_src;
  logic [7:0] out_data, cnt0, cnt1;
  logic s_r0, s_r1, s_ov, s_os;
  logic [7:0] s_od;
  logic [1:0] s_c0, s_c1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  codi_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .cnt0(cnt0), .cnt1(cnt1)
  );

  codi_arbiter #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(s_r0),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(s_r1),
    .out_valid(s_ov), .out_data(s_od), .out_src(s_os),
    .out_ready(out_ready), .cnt0(s_c0), .cnt1(s_c1)
  );

  // Reference encoder from the positional Hamming definition.
  function automatic logic [7:0] enc_ref(input logic [3:0] d);
    logic [7:0] c;
    int dp[4];
    dp = '{3, 5, 6, 7};
    c = '0;
    for (int k = 0; k < 4; k++) c[dp[k]] = d[k];
    for (int p = 1; p < 8; p = p * 2)
      for (int q = 1; q < 8; q++)
        if (((q & p) != 0) && (q != p)) c[p] = c[p] ^ c[q];
    c[0] = ^c[7:1];
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v0, input logic [3:0] d0,
                        input logic v1, input logic [3:0] d1, input logic ordy);
    req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1;
    out_ready  = ordy;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1, 4'hA, 1, 4'h5, 1);
    tick();
    total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++;
      $display("FAIL reset_ready got %b%b want 00", req0_ready, req1_ready); end
    total++; if (out_valid !== 1'b0 || out_src !== 1'b0) begin bad++;
      $display("FAIL reset_out got v=%b s=%b want 0 0", out_valid, out_src); end
    total++; if (out_data !== 8'h00) begin bad++;
      $display("FAIL reset_data got %h want 00", out_data); end
    total++; if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin bad++;
      $display("FAIL reset_cnt got %0d %0d want 0 0", cnt0, cnt1); end
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0);
  endtask

  task automatic test_single();
    reset_dut();
    set_in(1, 4'hF, 0, 4'h0, 1);
    #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++;
      $display("FAIL single_ready got %b%b want 10", req0_ready, req1_ready); end
    tick();
    set_in(0, 0, 0, 0, 0);
    total++; if (out_valid !== 1'b1 || out_data !== 8'hFF || out_src !== 1'b0) begin bad++;
      $display("FAIL single_out got v=%b d=%h s=%b want 1 ff 0", out_valid, out_data, out_src); end
    total++; if (cnt0 !== 8'd1) begin bad++;
      $display("FAIL single_cnt0 got %0d want 1", cnt0); end
  endtask

  task automatic test_tie();
    reset_dut();
    set_in(1, 4'h0, 1, 4'hF, 1);
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin bad++;
        $display("FAIL tie_ready[%0d] got %b%b", i, req0_ready, req1_ready); end
      tick();
      total++; if (out_valid !== 1'b1 || out_src !== 1'(i % 2) ||
                   out_data !== ((i % 2 == 1) ? 8'hFF : 8'h00)) begin bad++;
        $display("FAIL tie_out[%0d] got v=%b s=%b d=%h", i, out_valid, out_src, out_data); end
    end
    total++; if (cnt0 !== 8'd2 || cnt1 !== 8'd2) begin bad++;
      $display("FAIL tie_cnt got %0d %0d want 2 2", cnt0, cnt1); end
  endtask

  // Runs right after test_tie: stage holds req1's word, last grant = 1.
  task automatic test_backpressure();
    set_in(1, 4'h0, 1, 4'hF, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++;
        $display("FAIL bp_ready[%0d] got %b%b want 00", i, req0_ready, req1_ready); end
      tick();
      total++; if (out_valid !== 1'b1 || out_data !== 8'hFF || out_src !== 1'b1) begin bad++;
        $display("FAIL bp_hold[%0d] got v=%b d=%h s=%b", i, out_valid, out_data, out_src); end
    end
    out_ready = 1'b1;
    #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++;
      $display("FAIL bp_resume_ready got %b%b want 10", req0_ready, req1_ready); end
    tick();
    set_in(0, 0, 0, 0, 1);
    total++; if (out_src !== 1'b0 || out_data !== 8'h00) begin bad++;
      $display("FAIL bp_resume_out got s=%b d=%h want 0 00", out_src, out_data); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++;
      $display("FAIL bp_drain got v=%b want 0", out_valid); end
  endtask

  task automatic test_saturation();
    reset_dut();
    set_in(0, 0, 1, 4'h5, 1);
    for (int i = 0; i < 6; i++) tick();
    total++; if (s_c1 !== 2'd3) begin bad++;
      $display("FAIL sat_cnt1 got %0d want 3", s_c1); end
    total++; if (cnt1 !== 8'd6) begin bad++;
      $display("FAIL wide_cnt1 got %0d want 6", cnt1); end
    tick();
    set_in(0, 0, 0, 0, 1);
    total++; if (s_c1 !== 2'd3 || s_c0 !== 2'd0) begin bad++;
      $display("FAIL sat_hold got %0d %0d want 3 0", s_c1, s_c0); end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    set_in(1, 4'h6, 1, 4'h9, 0);
    tick();
    tick();
    total++; if (out_valid !== 1'b1) begin bad++;
      $display("FAIL mid_pre got v=%b want 1", out_valid); end
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || cnt0 !== 8'd0 || cnt1 !== 8'd0) begin bad++;
      $display("FAIL mid_rst got v=%b c=%0d/%0d want 0 0/0", out_valid, cnt0, cnt1); end
    tick();
    rst = 1'b0;
    set_in(1, 4'h3, 1, 4'hC, 1);
    #1;
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++;
      $display("FAIL mid_tie_ready got %b%b want 10", req0_ready, req1_ready); end
    tick();
    set_in(0, 0, 0, 0, 1);
    total++; if (out_src !== 1'b0 || out_data !== enc_ref(4'h3)) begin bad++;
      $display("FAIL mid_tie_out got s=%b d=%h want 0 %h", out_src, out_data, enc_ref(4'h3)); end
  endtask

  task automatic test_exhaustive();
    reset_dut();
    for (int v = 0; v < 16; v++) begin
      set_in(0, 0, 1, 4'(v), 1);
      tick();
      total++; if (out_valid !== 1'b1 || out_src !== 1'b1 || out_data !== enc_ref(4'(v))) begin bad++;
        $display("FAIL enc[%0d] got v=%b s=%b d=%h want 1 1 %h", v, out_valid, out_src, out_data, enc_ref(4'(v))); end
    end
    set_in(0, 0, 0, 0, 1);
    total++; if (cnt1 !== 8'd16 || s_c1 !== 2'd3) begin bad++;
      $display("FAIL enc_cnt got %0d/%0d want 16/3", cnt1, s_c1); end
  endtask

  task automatic test_random();
    logic m_valid, m_src, m_last, e0, e1, free;
    logic [7:0] m_data;
    int m_c0, m_c1;
    reset_dut();
    m_valid = 0; m_src = 0; m_last = 1; m_data = '0; m_c0 = 0; m_c1 = 0;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      set_in($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 3) != 0,
             4'($urandom), $urandom_range(0, 2) != 0);
      free = !m_valid || out_ready;
      e0 = !rst && free && req0_valid && (!req1_valid || m_last);
      e1 = !rst && free && req1_valid && (!req0_valid || !m_last);
      #1;
      total++; if (req0_ready !== e0 || req1_ready !== e1) begin bad++;
        $display("FAIL rnd_ready[%0d] got %b%b want %b%b", i, req0_ready, req1_ready, e0, e1); end
      tick();
      if (rst) begin
        m_valid = 0; m_src = 0; m_last = 1; m_data = '0; m_c0 = 0; m_c1 = 0;
      end else if (e0 || e1) begin
        m_valid = 1; m_src = e1; m_last = e1;
        m_data = enc_ref(e1 ? req1_data : req0_data);
        if (e1) m_c1++; else m_c0++;
      end else if (out_ready) begin
        m_valid = 0;
      end
      total++; if (out_valid !== m_valid) begin bad++;
        $display("FAIL rnd_valid[%0d] got %b want %b", i, out_valid, m_valid); end
      if (m_valid) begin
        total++; if (out_data !== m_data || out_src !== m_src) begin bad++;
          $display("FAIL rnd_out[%0d] got %h/%b want %h/%b", i, out_data, out_src, m_data, m_src); end
      end
      total++; if (cnt0 !== 8'((m_c0 > 255) ? 255 : m_c0) || cnt1 !== 8'((m_c1 > 255) ? 255 : m_c1)) begin bad++;
        $display("FAIL rnd_cnt[%0d] got %0d/%0d want %0d/%0d", i, cnt0, cnt1, m_c0, m_c1); end
      total++; if (s_c0 !== 2'((m_c0 > 3) ? 3 : m_c0) || s_c1 !== 2'((m_c1 > 3) ? 3 : m_c1)) begin bad++;
        $display("FAIL rnd_satcnt[%0d] got %0d/%0d", i, s_c0, s_c1); end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0);
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    test_exhaustive();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
